// File: rtl/cmem.sv
// Coefficient memory: DEPTH x WIDTH signed taps, one write and one registered read port.
// Optional CMEM_BYPASS_EN: same-address write+read returns the new word (write-first).
module cmem #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic                     clk2,
  input  logic                     rstn,
  input  logic                     cload,
  input  logic [ADDR_W-1:0]        caddr,
  input  logic signed [WIDTH-1:0]  cin,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [WIDTH-1:0]  cout
);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] rdata;
  logic                    wr;
  logic                    rd;

  assign wr = !rstn && cload;
  assign rd = !rstn && ren;

`ifdef CMEM_BYPASS_EN
  // Forward the incoming word when it targets the address being read.
  always_comb begin
    rdata = mem[raddr];
    if (cload && (caddr == raddr)) rdata = cin;
  end
`else
  // Read-first: the old word is returned; the new one is visible next cycle.
  always_comb begin
    rdata = mem[raddr];
  end
`endif

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk2) begin
    if (wr) mem[caddr] <= cin;
  end

  always_ff @(posedge clk2) begin
    if (rstn) begin
      cout <= '0;
    end else if (rd) begin
      cout <= rdata;
    end
  end

endmodule

// File: tb/tb_cmem.sv
// Self-checking bench for cmem: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_cmem;

  localparam int DEPTH  = 64;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;

`ifdef CMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                    clk2;
  logic                    rstn;
  logic                    cload;
  logic [ADDR_W-1:0]       caddr;
  logic signed [WIDTH-1:0] cin;
  logic                    ren;
  logic [ADDR_W-1:0]       raddr;
  logic signed [WIDTH-1:0] cout;

  logic signed [WIDTH-1:0] ref_mem [DEPTH];
  logic signed [WIDTH-1:0] exp_cout;

  int checks;
  int errors;

  cmem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk2  (clk2),
    .rstn  (rstn),
    .cload (cload),
    .caddr (caddr),
    .cin   (cin),
    .ren   (ren),
    .raddr (raddr),
    .cout  (cout)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // Apply one cycle of stimulus, advance the reference model, sample #1 after the edge.
  task automatic cycle(input bit rst, input bit wl,
                       input logic [ADDR_W-1:0] wa,
                       input logic signed [WIDTH-1:0] wd,
                       input bit rl,
                       input logic [ADDR_W-1:0] ra);
    rstn  = rst;
    cload = wl;
    caddr = wa;
    cin   = wd;
    ren   = rl;
    raddr = ra;
    if (rst) begin
      exp_cout = '0;
    end else begin
      if (rl) begin
        if (wl && wa == ra && BYP) exp_cout = wd;
        else exp_cout = ref_mem[ra];
      end
      if (wl) ref_mem[wa] = wd;
    end
    @(posedge clk2);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (cout !== 16'sd0) begin
      errors++;
      $display("FAIL reset_cout: got %h want 0000", cout);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 6'($urandom));
      checks++;
      if (cout !== 16'sd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want 0000", i, cout);
      end
    end
  endtask

  task automatic test_fill();
    logic signed [WIDTH-1:0] vals [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = 16'($urandom);
      cycle(1'b0, 1'b1, 6'(i), vals[i], 1'b0, '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 6'(i));
      checks++;
      if (cout !== vals[i]) begin
        errors++;
        $display("FAIL fill_read[%0d]: got %h want %h", i, cout, vals[i]);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b1, 6'd5, 16'sh8000, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 6'd5);
    checks++;
    if (cout !== -16'sd32768) begin
      errors++;
      $display("FAIL hold_read: got %h want 8000", cout);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 6'($urandom));
      checks++;
      if (cout !== -16'sd32768) begin
        errors++;
        $display("FAIL hold_keep[%0d]: got %h want 8000", i, cout);
      end
    end
  endtask

  task automatic test_collision();
    logic signed [WIDTH-1:0] want;
    cycle(1'b0, 1'b1, 6'd10, 16'sh0001, 1'b0, '0);
    cycle(1'b0, 1'b1, 6'd10, 16'sh1234, 1'b1, 6'd10);
    want = BYP ? 16'sh1234 : 16'sh0001;
    checks++;
    if (cout !== want) begin
      errors++;
      $display("FAIL collision: got %h want %h", cout, want);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 6'd10);
    checks++;
    if (cout !== 16'sh1234) begin
      errors++;
      $display("FAIL collision_next: got %h want 1234", cout);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 6'd3, 16'sh7FFF, 1'b1, 6'd7);
    cycle(1'b1, 1'b1, 6'd3, 16'sh0000, 1'b1, 6'd3);
    checks++;
    if (cout !== 16'sd0) begin
      errors++;
      $display("FAIL reset_mid_cout: got %h want 0000", cout);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 6'd3);
    checks++;
    if (cout !== 16'sh7FFF) begin
      errors++;
      $display("FAIL reset_mid_keep: got %h want 7fff", cout);
    end
  endtask

  task automatic test_concurrent();
    logic signed [WIDTH-1:0] old0;
    logic signed [WIDTH-1:0] nv;
    old0 = ref_mem[0];
    nv = 16'($urandom);
    if (nv == ref_mem[63]) nv = ~nv;
    cycle(1'b0, 1'b1, 6'd63, nv, 1'b1, 6'd0);
    checks++;
    if (cout !== old0) begin
      errors++;
      $display("FAIL concurrent_rd: got %h want %h", cout, old0);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 6'd63);
    checks++;
    if (cout !== nv) begin
      errors++;
      $display("FAIL concurrent_wr: got %h want %h", cout, nv);
    end
  endtask

  task automatic test_random();
    bit rst;
    bit wl;
    bit rl;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      wl  = $urandom_range(0, 1) == 1;
      rl  = $urandom_range(0, 3) != 0;
      wa  = 6'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom);
      cycle(rst, wl, wa, 16'($urandom), rl, ra);
      checks++;
      if (cout !== exp_cout) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, cout, exp_cout);
      end
    end
  endtask

  initial begin
    rstn  = 1'b1;
    cload = 1'b0;
    caddr = '0;
    cin   = '0;
    ren   = 1'b0;
    raddr = '0;
    exp_cout = '0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    test_reset();
    test_fill();
    test_hold();
    test_collision();
    test_reset_mid();
    test_concurrent();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
